dff_share_arbiter: RTL and testbench
====================================

Name: dff_share_arbiter

Overview:
Round-robin arbiter and write sequencer for one shared WIDTH-bit D-flip-flop storage register with complementary outputs (q/qbar). NREQ requesters compete for write access. The block grants one requester, performs the register load, acknowledges it, and holds ownership for a fixed window before re-arbitrating. It sits between requesting control logic and the shared state register.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, register data width (1..32)
HOLD_CYCLES, 2, cycles ownership is held after the write (1..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req  input  NREQ  request per requester; level, held until ack
wdata  input  NREQ*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, registered
ack  output  NREQ  one-cycle write-done pulse, registered
q  output  WIDTH  shared register contents
qbar  output  WIDTH  bitwise complement of q, always
owner  output  clog2(NREQ)  index of last/current grantee
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset, sampled on a clk edge while reset=1: q=0; qbar=all ones; gnt=0; ack=0; owner=0; busy=0; state=IDLE; rr pointer set so requester 0 has top priority.
- Reset mid-operation: the same values on the next edge. An in-flight write is dropped with no ack. Reset overrides all other inputs.
- States: IDLE, WRITE, HOLD.
- IDLE, any req high at edge N: pick the winner by round-robin, searching from (owner+1) mod NREQ upward with wrap. At N+1: gnt[w]=1, owner=w, busy=1, state=WRITE.
- IDLE, no req: stay in IDLE. q is unchanged; gnt and ack stay 0.
- WRITE (one cycle):
  - If req[w] is still high: q<=wdata[w] and ack[w]=1, both visible next cycle; state goes to HOLD.
  - If req[w] dropped: abort. No write, no ack, gnt cleared, state goes to IDLE. The rr pointer still advances (owner=w).
- HOLD: lasts exactly HOLD_CYCLES cycles.
  - gnt[w] stays high; q is stable; ack is high only in the first HOLD cycle.
  - On exit: gnt=0, busy=0, state=IDLE.
  - Requests arriving during WRITE/HOLD are not granted until IDLE.
- Latency:
  - req seen in IDLE at edge N → gnt at N+1 → q and ack at N+2 → gnt low at N+2+HOLD_CYCLES.
  - Minimum spacing between consecutive grants is HOLD_CYCLES+2 cycles.
- Fairness: the requester just served has the lowest priority in the next arbitration. With all requesters active, grant order is 0,1,…,NREQ-1,0 (wrap).
- gnt is always one-hot or zero. ack is always a subset of gnt.
- qbar is purely derived from q (~q); it has no independent state.
- A requester must keep wdata stable from request until its ack.

Optional Feature:
Macro DFF_SHARE_ARBITER_CLEAR_EN.
- With the macro: adds input port clear (1 bit).
  - clear=1 in IDLE: q<=0 next edge. Clear has priority over a new grant; that arbitration is deferred one cycle.
  - clear in WRITE/HOLD is ignored.
- Without the macro: no clear port. q changes only via a granted write or reset.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, req=0 → q=8'h00, qbar=8'hFF, gnt=0, busy=0, owner=0 for 10 cycles.
- Single write: req=4'b0100, wdata[2]=8'hA5 → gnt=4'b0100 at N+1; q=8'hA5, qbar=8'h5A, ack=4'b0100 for one cycle at N+2; gnt=0 at N+4; owner=2.
- Round-robin fairness: req=4'b1111 held, wdata[i]=8'h10+i, deassert each req on its ack → acks in order 0,1,2,3; grant-to-grant spacing 4 cycles; final q=8'h13.
- Abort: req=4'b0001, drop req[0] in the WRITE cycle → no ack, q unchanged, busy low the next cycle, owner=0, next req=4'b0011 grants requester 1 first.
- Reset mid-HOLD: after a write of 8'h3C, assert reset during HOLD → next cycle q=0, qbar=8'hFF, gnt=0, ack=0, state IDLE.
- Clear (with DFF_SHARE_ARBITER_CLEAR_EN): q=8'h77, in IDLE assert clear with req=4'b0010 → q=0 next cycle; grant to requester 1 one cycle later; q=wdata[1] afterward.

Source files
------------

// File: rtl/dff_share_arbiter.sv
// Round-robin write arbiter for one shared WIDTH-bit register with q/qbar outputs.
// Optional synchronous clear port enabled by defining DFF_SHARE_ARBITER_CLEAR_EN.
module dff_share_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef DFF_SHARE_ARBITER_CLEAR_EN
    input  logic                      clear,
`endif
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           ack,
    output logic [WIDTH-1:0]          q,
    output logic [WIDTH-1:0]          qbar,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [NREQ-1:0]   gnt_r, gnt_s;
    logic [NREQ-1:0]   ack_r, ack_s;
    logic [WIDTH-1:0]  q_r, q_s;
    logic [OW-1:0]     owner_r, owner_s;
    logic [OW-1:0]     ptr_r, ptr_s;
    logic              busy_r, busy_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [OW-1:0]     win_s;
    logic [OW-1:0]     cand_s;
    logic              found_s;
    logic              clear_s;

    function automatic logic [NREQ-1:0] to_onehot(input logic [OW-1:0] idx);
        to_onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // The requester after the winner becomes top priority next time round.
    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] idx);
        if (idx == OW'(NREQ - 1)) begin
            next_idx = '0;
        end else begin
            next_idx = idx + OW'(1'b1);
        end
    endfunction

`ifdef DFF_SHARE_ARBITER_CLEAR_EN
    assign clear_s = clear;
`else
    assign clear_s = 1'b0;
`endif

    // Round-robin search starting at the priority pointer, wrapping once.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        cand_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = OW'((int'(ptr_r) + i) % NREQ);
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
                win_s   = win_s;
            end
        end
    end

    // Next-state and next-output decode for the IDLE/WRITE/HOLD sequencer.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        ack_s   = '0;
        q_s     = q_r;
        owner_s = owner_r;
        ptr_s   = ptr_r;
        busy_s  = busy_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                gnt_s  = '0;
                busy_s = 1'b0;
                if (clear_s) begin
                    q_s = '0;
                end else if (found_s) begin
                    gnt_s   = to_onehot(win_s);
                    owner_s = win_s;
                    ptr_s   = next_idx(win_s);
                    busy_s  = 1'b1;
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // A requester that lets go before the write loses the slot.
                if (req[owner_r]) begin
                    q_s     = wdata[owner_r*WIDTH +: WIDTH];
                    ack_s   = gnt_r;
                    cnt_s   = CW'(HOLD_CYCLES - 1);
                    state_s = ST_HOLD;
                end else begin
                    gnt_s   = '0;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_r == '0) begin
                    gnt_s   = '0;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - CW'(1'b1);
                end
            end
            default: begin
                gnt_s   = '0;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            gnt_r   <= '0;
            ack_r   <= '0;
            q_r     <= '0;
            owner_r <= '0;
            ptr_r   <= '0;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            ack_r   <= ack_s;
            q_r     <= q_s;
            owner_r <= owner_s;
            ptr_r   <= ptr_s;
            busy_r  <= busy_s;
            cnt_r   <= cnt_s;
        end
    end

    assign gnt   = gnt_r;
    assign ack   = ack_r;
    assign q     = q_r;
    assign qbar  = ~q_r;
    assign owner = owner_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Scoreboard bench for dff_share_arbiter: directed scenarios plus random request batches.
module tb_dff_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int HOLD  = 2;
    localparam int OW    = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt, ack;
    logic [WIDTH-1:0]      q, qbar;
    logic [OW-1:0]         owner;
    logic                  busy;
`ifdef DFF_SHARE_ARBITER_CLEAR_EN
    logic                  clear;
`endif

    dff_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset),
`ifdef DFF_SHARE_ARBITER_CLEAR_EN
        .clear(clear),
`endif
        .req(req), .wdata(wdata), .gnt(gnt), .ack(ack),
        .q(q), .qbar(qbar), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] data;
        bit               spaced;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_ack_cyc = 0;
    int   model_next = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Monitor: invariants every cycle, and scoreboard pop on every ack.
    always @(negedge clk) begin
        if (!reset) begin
            exp_t e;
            chk("qbar_is_not_q", qbar, {~q});
            chk("gnt_onehot0", {63'd0, $onehot0(gnt)}, 64'd1);
            chk("ack_within_gnt", ack & {~gnt}, 64'd0);
            if (ack != '0) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack=%b with nothing expected (cycle %0d)", ack, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("ack_vector", ack, 64'd1 << e.idx);
                    chk("q_after_write", q, e.data);
                    chk("qbar_after_write", qbar, {~e.data});
                    if (e.spaced) chk("grant_spacing", cyc - last_ack_cyc, HOLD + 2);
                    last_ack_cyc = cyc;
                end
            end
        end
    end

    // Expected order: requesters in the mask, scanned upward from the rr start with wrap.
    task automatic expect_batch(input logic [NREQ-1:0] mask, input logic [NREQ*WIDTH-1:0] data);
        exp_t e;
        bit   first = 1'b1;
        int   last = model_next;
        for (int k = 0; k < NREQ; k++) begin
            int i = (model_next + k) % NREQ;
            if (mask[i]) begin
                e.idx = i;
                e.data = data[i*WIDTH +: WIDTH];
                e.spaced = !first;
                sbq.push_back(e);
                first = 1'b0;
                last = i;
            end
        end
        model_next = (last + 1) % NREQ;
    endtask

    // Requesters drop their line on ack; bounded wait for everything to settle.
    task automatic drain();
        int budget = 100;
        while (req != '0 && budget > 0) begin
            step();
            req = req & ~ack;
            budget--;
        end
        if (req != '0) begin
            checks++;
            errors++;
            $display("FAIL batch_timeout: req=%b still pending, required 0", req);
            req = '0;
        end
        budget = 20;
        while (busy && budget > 0) begin
            step();
            budget--;
        end
        step();
        chk("scoreboard_drained", sbq.size(), 64'd0);
    endtask

    task automatic run_batch(input logic [NREQ-1:0] mask, input logic [NREQ*WIDTH-1:0] data);
        wdata = data;
        expect_batch(mask, data);
        req = mask;
        drain();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_q"}, q, 64'h00);
        chk({tag, "_qbar"}, qbar, 64'hFF);
        chk({tag, "_gnt"}, gnt, 64'd0);
        chk({tag, "_ack"}, ack, 64'd0);
        chk({tag, "_busy"}, busy, 64'd0);
        chk({tag, "_owner"}, owner, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] q_before;
        logic [NREQ*WIDTH-1:0] rdata;
        int budget;
        reset = 1'b1;
        req = '0;
        wdata = '0;
`ifdef DFF_SHARE_ARBITER_CLEAR_EN
        clear = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check_reset_values("idle");
        end

        // Fairness: all four requesting, acks 0..3 four cycles apart.
        run_batch(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10});
        chk("fair_final_q", q, 64'h13);

        // Single write with cycle-accurate latency checks.
        wdata = $urandom;
        wdata[2*WIDTH +: WIDTH] = 8'hA5;
        expect_batch(4'b0100, wdata);
        req = 4'b0100;
        step();
        chk("sw_gnt", gnt, 64'b0100);
        chk("sw_busy", busy, 64'd1);
        chk("sw_no_ack_yet", ack, 64'd0);
        step();
        chk("sw_ack", ack, 64'b0100);
        chk("sw_qbar", qbar, 64'h5A);
        req = 4'b0000;
        step();
        chk("sw_ack_pulse", ack, 64'd0);
        chk("sw_gnt_held", gnt, 64'b0100);
        chk("sw_q_stable", q, 64'hA5);
        step();
        chk("sw_gnt_release", gnt, 64'd0);
        chk("sw_busy_release", busy, 64'd0);
        chk("sw_owner", owner, 64'd2);

        // Abort: requester 0 drops its line during WRITE.
        q_before = q;
        wdata = $urandom;
        req = 4'b0001;
        step();
        chk("ab_gnt", gnt, 64'b0001);
        req = 4'b0000;
        step();
        chk("ab_busy", busy, 64'd0);
        chk("ab_gnt_clear", gnt, 64'd0);
        chk("ab_q", q, q_before);
        chk("ab_owner", owner, 64'd0);
        model_next = 1;
        step();
        step();
        run_batch(4'b0011, $urandom);

        // Reset during WRITE drops the write.
        wdata = $urandom;
        req = 4'b0100;
        step();
        chk("rw_gnt", gnt, 64'b0100);
        reset = 1'b1;
        req = '0;
        step();
        check_reset_values("rw");
        reset = 1'b0;
        model_next = 0;
        step();

        // Reset during HOLD after a write of 3C.
        wdata = $urandom;
        wdata[0 +: WIDTH] = 8'h3C;
        expect_batch(4'b0001, wdata);
        req = 4'b0001;
        budget = 10;
        while (ack == '0 && budget > 0) begin
            step();
            budget--;
        end
        chk("rh_ack_seen", ack, 64'b0001);
        reset = 1'b1;
        req = '0;
        step();
        check_reset_values("rh");
        reset = 1'b0;
        model_next = 0;
        sbq.delete();
        step();

`ifdef DFF_SHARE_ARBITER_CLEAR_EN
        // Clear in IDLE beats a simultaneous request, which is served one cycle later.
        rdata = $urandom;
        rdata[1*WIDTH +: WIDTH] = 8'h77;
        run_batch(4'b0010, rdata);
        chk("cl_q_before", q, 64'h77);
        rdata = $urandom;
        rdata[1*WIDTH +: WIDTH] = 8'hC3;
        wdata = rdata;
        expect_batch(4'b0010, rdata);
        clear = 1'b1;
        req = 4'b0010;
        step();
        clear = 1'b0;
        chk("cl_q_zero", q, 64'h00);
        chk("cl_gnt_deferred", gnt, 64'd0);
        step();
        chk("cl_gnt", gnt, 64'b0010);
        drain();
        chk("cl_q_after", q, 64'hC3);
`endif

        // Random batches of requesters.
        for (int b = 0; b < 30; b++) begin
            logic [NREQ-1:0] mask;
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            rdata = $urandom;
            run_batch(mask, rdata);
            chk("rand_owner", owner, (model_next + NREQ - 1) % NREQ);
            repeat ($urandom_range(0, 3)) step();
        end

        chk("final_sb_empty", sbq.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
